pconv_packer: RTL and testbench

PCONV_PACKER -- requirements
Module: pconv_packer

---
 rtl/pconv_packer.sv | 100 ++++++++++
 tb/tb_pconv_packer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pconv_packer.sv
// Packs a stream of partial-convolution elements into one wide vector for the conv core.
// Element k lands in slot k (element 0 in the LSBs); the layer tag travels with element 0.
module pconv_packer #(
    parameter int PCONV_LEN = 19,
    parameter int PCONV_NUM = 53
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_flush,
    input  logic [1:0]                     i_layer_num,
    input  logic                           i_valid,
    input  logic [PCONV_LEN-1:0]           i_elem,
    output logic                           o_ready,
    output logic [PCONV_LEN*PCONV_NUM-1:0] o_pconv,
    output logic [1:0]                     o_layer_num,
    output logic                           o_valid,
    input  logic                           i_ready
);

    localparam int               CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PCONV_NUM - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [PCONV_LEN*PCONV_NUM-1:0] pconv_q, pconv_d;
    logic [1:0]                     layer_q, layer_d;
    logic                           transfer;
    logic                           accept;

    assign transfer = i_valid && o_ready;
    // A flush in the same cycle wins over the element offered with it.
    assign accept   = transfer && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (transfer && (cnt_q == LAST)) state_d = FULL;
                FULL:    if (i_ready) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        o_ready = (state_q == FILL);
        o_valid = (state_q == FULL);
    end

    always_comb begin
        cnt_d   = cnt_q;
        pconv_d = pconv_q;
        layer_d = layer_q;
        if (i_flush) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
                layer_d = i_layer_num;
            end
            for (int k = 0; k < PCONV_NUM; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    pconv_d[k*PCONV_LEN +: PCONV_LEN] = i_elem;
                end
            end
        end
    end

    // Slots are never cleared except by reset; every slot is rewritten before the next FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pconv_q <= '0;
            layer_q <= 2'b00;
        end else begin
            cnt_q   <= cnt_d;
            pconv_q <= pconv_d;
            layer_q <= layer_d;
        end
    end

    assign o_pconv     = pconv_q;
    assign o_layer_num = layer_q;

endmodule

// File: tb/tb_pconv_packer.sv
// Randomized bench for pconv_packer, checked against a queue-based model of accepted elements.
module tb_pconv_packer;

    localparam int LEN = 19;
    localparam int NUM = 53;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_flush = 1'b0;
    logic [1:0]           i_layer_num = 2'b00;
    logic                 i_valid = 1'b0;
    logic [LEN-1:0]       i_elem = '0;
    logic                 o_ready;
    logic [LEN*NUM-1:0]   o_pconv;
    logic [1:0]           o_layer_num;
    logic                 o_valid;
    logic                 i_ready = 1'b0;

    int checkCount = 0;
    int failCount  = 0;
    int validSeen  = 0;

    logic [LEN-1:0] mElems[$];
    logic           mFull  = 1'b0;
    logic [1:0]     mLayer = 2'b00;

    pconv_packer #(.PCONV_LEN(LEN), .PCONV_NUM(NUM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_flush(i_flush),
        .i_layer_num(i_layer_num),
        .i_valid(i_valid),
        .i_elem(i_elem),
        .o_ready(o_ready),
        .o_pconv(o_pconv),
        .o_layer_num(o_layer_num),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare DUT outputs against the model's view of the current cycle.
    task automatic checkModel();
        if (o_valid === 1'b1) validSeen++;
        checkOutput("o_valid", 32'(o_valid), 32'(mFull));
        checkOutput("o_ready", 32'(o_ready), 32'(!mFull));
        if (mFull) begin
            checkOutput("o_layer_num", 32'(o_layer_num), 32'(mLayer));
            for (int k = 0; k < NUM; k++) begin
                checkOutput($sformatf("slot%0d", k), 32'(o_pconv[k*LEN +: LEN]), 32'(mElems[k]));
            end
        end
    endtask

    // Drive one cycle of inputs, check outputs, then advance the model past the coming edge.
    task automatic applyStimulus(input logic v, input logic [LEN-1:0] e, input logic [1:0] ln,
                                 input logic fl, input logic rd);
        @(negedge clk);
        i_valid     = v;
        i_elem      = e;
        i_layer_num = ln;
        i_flush     = fl;
        i_ready     = rd;
        checkModel();
        if (fl) begin
            mElems.delete();
            mFull = 1'b0;
        end else if (!mFull) begin
            if (v) begin
                if (mElems.size() == 0) mLayer = ln;
                mElems.push_back(e);
                if (mElems.size() == NUM) mFull = 1'b1;
            end
        end else if (rd) begin
            mElems.delete();
            mFull = 1'b0;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        #1;
        checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_o_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_layer", 32'(o_layer_num), 32'd0);
        checkOutput("rst_pconv_zero", 32'(o_pconv == '0), 32'd1);
        mElems.delete();
        mFull = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [LEN-1:0] rndElem();
        return LEN'($urandom);
    endfunction

    function automatic logic [1:0] rndLayer();
        return 2'($urandom);
    endfunction

    initial begin
        $display("[TB] start");
        doReset();

        // Partial fill to 20 elements, then reset mid-vector.
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, rndElem(), rndLayer(), 1'b0, 1'b0);
        doReset();

        // Stream k+1 with layer 2, then hold FULL under backpressure.
        for (int k = 0; k < NUM; k++) begin
            applyStimulus(1'b1, LEN'(k + 1), (k == 0) ? 2'd2 : rndLayer(), 1'b0, 1'b0);
        end
        for (int c = 0; c < 10; c++) applyStimulus(1'b1, rndElem(), rndLayer(), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stream_slot0", 32'(o_pconv[18:0]), 32'd1);
        checkOutput("stream_slot52", 32'(o_pconv[1006:988]), 32'd53);
        checkOutput("stream_layer", 32'(o_layer_num), 32'd2);

        // Handoff: element offered during the handoff cycle must be ignored.
        applyStimulus(1'b1, rndElem(), rndLayer(), 1'b0, 1'b1);

        // Bubbles with a changing layer tag.
        for (int c = 0; c < 400 && !mFull; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), rndElem(), rndLayer(), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, rndElem(), rndLayer(), 1'b0, 1'b0);
        applyStimulus(1'b0, rndElem(), rndLayer(), 1'b0, 1'b1);

        // Flush at cnt=30 with a valid element, then flush together with i_ready in FULL.
        for (int k = 0; k < 30; k++) applyStimulus(1'b1, rndElem(), rndLayer(), 1'b0, 1'b0);
        applyStimulus(1'b1, rndElem(), rndLayer(), 1'b1, 1'b0);
        for (int k = 0; k < NUM; k++) applyStimulus(1'b1, rndElem(), rndLayer(), 1'b0, 1'b0);
        applyStimulus(1'b1, rndElem(), rndLayer(), 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, rndElem(), rndLayer(), 1'b0, 1'b0);

        // Back-to-back full throughput.
        validSeen = 0;
        for (int c = 0; c < 540; c++) applyStimulus(1'b1, rndElem(), rndLayer(), 1'b0, 1'b1);
        checkOutput("b2b_vectors", 32'(validSeen), 32'd10);

        // Random mix of all controls, flush kept rare.
        for (int c = 0; c < 600; c++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), rndElem(), rndLayer(),
                          1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) == 0));
        end
        @(negedge clk);
        checkModel();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
